amber128_dmem_bridge: RTL and testbench

//  Sits between the amber128 core DMEM port and the 64-bit system data bus.

---
 rtl/amber128_pkg.sv | 16 +
 rtl/amber128_dmem_bridge.sv | 183 ++++++++++++++++++
 tb/tb_amber128_dmem_bridge.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/amber128_pkg.sv
// Shared amber128 definitions: system data bus geometry and DMEM bridge FSM states.
package amber128_pkg;

  localparam int DBUS_W          = 64;
  localparam int DBUS_BEAT_BYTES = 8;

  typedef enum logic [2:0] {
    DBR_IDLE,
    DBR_REQ0,
    DBR_RSP0,
    DBR_REQ1,
    DBR_RSP1,
    DBR_DONE
  } amber128_dbr_state_e;

endpackage

// File: rtl/amber128_dmem_bridge.sv
// Splits each 128-bit core DMEM access into two 64-bit split-transaction bus beats
// and returns a single ready pulse (with trap) to the core.
module amber128_dmem_bridge
  import amber128_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clk_en_i,
  input  logic                core_req_i,
  input  logic                core_we_i,
  input  logic [63:0]         core_addr_i,
  input  logic [127:0]        core_wdata_i,
  output logic [127:0]        core_rdata_o,
  output logic                core_ready_o,
  output logic                core_trap_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [63:0]         bus_addr_o,
  output logic [DBUS_W-1:0]   bus_wdata_o,
  input  logic                bus_gnt_i,
  input  logic                bus_rvalid_i,
  input  logic [DBUS_W-1:0]   bus_rdata_i,
  input  logic                bus_err_i
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Last count before the counter would reach TIMEOUT_CYCLES.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  amber128_dbr_state_e state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [63:0]         addr_q, addr_d;
  logic [127:0]        wdata_q, wdata_d;
  logic [DBUS_W-1:0]   rlo_q, rlo_d;
  logic [127:0]        rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                trap_q, trap_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [63:0]         bus_addr_q, bus_addr_d;
  logic [DBUS_W-1:0]   bus_wdata_q, bus_wdata_d;

  logic busy, timeout, fin_trap;

  assign busy    = (state_q == DBR_REQ0) || (state_q == DBR_RSP0) ||
                   (state_q == DBR_REQ1) || (state_q == DBR_RSP1);
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rlo_d       = rlo_q;
    rdata_d     = rdata_q;
    ready_d     = ready_q;
    trap_d      = trap_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    fin_trap    = 1'b0;

    unique case (state_q)
      DBR_IDLE: begin
        if (core_req_i) begin
          we_d    = core_we_i;
          addr_d  = core_addr_i;
          wdata_d = core_wdata_i;
          if (core_addr_i[3:0] != 4'h0) begin
            fin_trap = 1'b1;
          end else begin
            state_d     = DBR_REQ0;
            bus_req_d   = 1'b1;
            bus_we_d    = core_we_i;
            bus_addr_d  = core_addr_i;
            bus_wdata_d = core_wdata_i[63:0];
          end
        end
      end
      DBR_REQ0, DBR_REQ1: begin
        if (bus_gnt_i) begin
          bus_req_d = 1'b0;
          state_d   = (state_q == DBR_REQ0) ? DBR_RSP0 : DBR_RSP1;
        end else if (timeout) begin
          fin_trap = 1'b1;
        end
      end
      DBR_RSP0: begin
        if (bus_rvalid_i) begin
          if (bus_err_i) begin
            fin_trap = 1'b1;
          end else begin
            rlo_d       = bus_rdata_i;
            state_d     = DBR_REQ1;
            bus_req_d   = 1'b1;
            bus_addr_d  = addr_q + 64'(DBUS_BEAT_BYTES);
            bus_wdata_d = wdata_q[127:64];
          end
        end else if (timeout) begin
          fin_trap = 1'b1;
        end
      end
      DBR_RSP1: begin
        if (bus_rvalid_i) begin
          if (bus_err_i) begin
            fin_trap = 1'b1;
          end else begin
            state_d = DBR_DONE;
            ready_d = 1'b1;
            trap_d  = 1'b0;
            rdata_d = we_q ? 128'h0 : {bus_rdata_i, rlo_q};
          end
        end else if (timeout) begin
          fin_trap = 1'b1;
        end
      end
      DBR_DONE: begin
        ready_d = 1'b0;
        state_d = DBR_IDLE;
      end
      default: state_d = DBR_IDLE;
    endcase

    if (fin_trap) begin
      state_d   = DBR_DONE;
      ready_d   = 1'b1;
      trap_d    = 1'b1;
      rdata_d   = 128'h0;
      bus_req_d = 1'b0;
    end

    // Counter restarts on every state change so each phase gets a full budget.
    if (state_d != state_q) cnt_d = '0;
    else if (busy)          cnt_d = cnt_q + CW'(1);
    else                    cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= DBR_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rlo_q       <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      trap_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else if (clk_en_i) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rlo_q       <= rlo_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      trap_q      <= trap_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // The pulse is gated so a frozen DONE never shows ready in a disabled cycle.
  assign core_ready_o = ready_q & clk_en_i;
  assign core_trap_o  = trap_q;
  assign core_rdata_o = rdata_q;
  assign bus_req_o    = bus_req_q;
  assign bus_we_o     = bus_we_q;
  assign bus_addr_o   = bus_addr_q;
  assign bus_wdata_o  = bus_wdata_q;

endmodule

// File: tb/tb_amber128_dmem_bridge.sv
// Directed bench for amber128_dmem_bridge with a simple enable-aware bus responder.
module tb_amber128_dmem_bridge;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         clk_en_i;
  logic         core_req_i;
  logic         core_we_i;
  logic [63:0]  core_addr_i;
  logic [127:0] core_wdata_i;
  logic [127:0] core_rdata_o;
  logic         core_ready_o;
  logic         core_trap_o;
  logic         bus_req_o;
  logic         bus_we_o;
  logic [63:0]  bus_addr_o;
  logic [63:0]  bus_wdata_o;
  logic         bus_gnt_i;
  logic         bus_rvalid_i;
  logic [63:0]  bus_rdata_i;
  logic         bus_err_i;

  int checks = 0;
  int errors = 0;

  // responder controls and records
  logic        gnt_en   = 1'b1;
  int          err_beat = -1;
  logic        late_rv  = 1'b0;
  logic        pending  = 1'b0;
  int          pend_idx = 0;
  int          beat_cnt = 0;
  logic        req_seen = 1'b0;
  logic [63:0] rsp_data [2];
  logic [63:0] beat_addr [4];
  logic        beat_we [4];
  logic [63:0] beat_wdata [4];

  localparam logic [63:0] D1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] D2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] WA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] WB = 64'hBBBB_BBBB_BBBB_BBBB;

  amber128_dmem_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clk_en_i(clk_en_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_rdata_o(core_rdata_o),
    .core_ready_o(core_ready_o), .core_trap_o(core_trap_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
  );

  always #5 clk_i = ~clk_i;

  // Bus responder: grants in the request cycle, answers one enabled cycle later.
  initial begin
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0; bus_err_i = 1'b0;
    forever begin
      @(posedge clk_i); #2;
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
      if (!rst_ni) begin
        pending = 1'b0;
      end else if (late_rv) begin
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 64'hDEAD_BEEF_DEAD_BEEF;
        late_rv      = 1'b0;
      end else if (clk_en_i) begin
        if (pending) begin
          bus_rvalid_i = 1'b1;
          bus_rdata_i  = rsp_data[pend_idx % 2];
          bus_err_i    = (pend_idx == err_beat);
          pending      = 1'b0;
        end else if (bus_req_o && gnt_en) begin
          bus_gnt_i = 1'b1;
          if (beat_cnt < 4) begin
            beat_addr[beat_cnt]  = bus_addr_o;
            beat_we[beat_cnt]    = bus_we_o;
            beat_wdata[beat_cnt] = bus_wdata_o;
          end
          pend_idx = beat_cnt;
          beat_cnt = beat_cnt + 1;
          pending  = 1'b1;
        end
      end
      if (bus_req_o) req_seen = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  // Drives one request until ready (bounded), then drops it and samples the next cycle.
  task automatic do_req(input logic we, input logic [63:0] addr, input logic [127:0] wd,
                        output int lat, output logic [127:0] rd, output logic tr,
                        output logic extra);
    core_req_i = 1'b1; core_we_i = we; core_addr_i = addr; core_wdata_i = wd;
    lat = -1; rd = '0; tr = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (core_ready_o) begin
        lat = i; rd = core_rdata_o; tr = core_trap_o;
        break;
      end
    end
    core_req_i = 1'b0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL ready_wait: no core_ready_o within 40 cycles for addr %h", addr);
    end
    tick();
    extra = core_ready_o;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; clk_en_i = 1'b1; core_req_i = 1'b0; core_we_i = 1'b0;
    core_addr_i = '0; core_wdata_i = '0;
    #3;
    checks++;
    if ({core_ready_o, core_trap_o, bus_req_o, bus_we_o} !== 4'b0000 ||
        core_rdata_o !== '0 || bus_addr_o !== '0 || bus_wdata_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b trap=%b req=%b we=%b rdata=%h addr=%h wdata=%h, want all 0",
               core_ready_o, core_trap_o, bus_req_o, bus_we_o, core_rdata_o, bus_addr_o, bus_wdata_o);
    end
    tick(); tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_load();
    int lat; logic [127:0] rd; logic tr, ex;
    beat_cnt = 0; rsp_data[0] = D1; rsp_data[1] = D2;
    do_req(1'b0, 64'h100, '0, lat, rd, tr, ex);
    checks++; if (lat !== 5) begin errors++; $display("FAIL ld_latency: got %0d want 5", lat); end
    checks++; if (rd !== {D2, D1}) begin errors++; $display("FAIL ld_rdata: got %h want %h", rd, {D2, D1}); end
    checks++; if (tr !== 1'b0) begin errors++; $display("FAIL ld_trap: got %b want 0", tr); end
    checks++; if (beat_cnt !== 2) begin errors++; $display("FAIL ld_beats: got %0d want 2", beat_cnt); end
    checks++;
    if (beat_addr[0] !== 64'h100 || beat_addr[1] !== 64'h108) begin
      errors++; $display("FAIL ld_addr: got %h,%h want 100,108", beat_addr[0], beat_addr[1]);
    end
    checks++; if (ex !== 1'b0) begin errors++; $display("FAIL ld_single_pulse: ready after pulse=%b want 0", ex); end
  endtask

  task automatic test_store();
    int lat; logic [127:0] rd; logic tr, ex;
    beat_cnt = 0;
    do_req(1'b1, 64'h2F0, {WA, WB}, lat, rd, tr, ex);
    checks++;
    if (beat_wdata[0] !== WB || beat_wdata[1] !== WA || beat_addr[0] !== 64'h2F0 ||
        beat_addr[1] !== 64'h2F8 || beat_we[0] !== 1'b1 || beat_we[1] !== 1'b1) begin
      errors++;
      $display("FAIL st_beats: a0=%h d0=%h a1=%h d1=%h we=%b%b want 2f0/bbbb.. 2f8/aaaa.. we=11",
               beat_addr[0], beat_wdata[0], beat_addr[1], beat_wdata[1], beat_we[0], beat_we[1]);
    end
    checks++;
    if (lat !== 5 || tr !== 1'b0 || rd !== '0 || ex !== 1'b0) begin
      errors++; $display("FAIL st_done: lat=%0d trap=%b rdata=%h extra=%b want 5/0/0/0", lat, tr, rd, ex);
    end
  endtask

  task automatic test_misaligned();
    int lat; logic [127:0] rd; logic tr, ex;
    beat_cnt = 0; req_seen = 1'b0;
    do_req(1'b0, 64'h104, '0, lat, rd, tr, ex);
    checks++;
    if (lat !== 1 || tr !== 1'b1 || rd !== '0) begin
      errors++; $display("FAIL misaligned: lat=%0d trap=%b rdata=%h want 1/1/0", lat, tr, rd);
    end
    checks++;
    if (req_seen !== 1'b0 || beat_cnt !== 0) begin
      errors++; $display("FAIL misaligned_nobus: req_seen=%b beats=%0d want 0/0", req_seen, beat_cnt);
    end
  endtask

  task automatic test_bus_err();
    int lat; logic [127:0] rd; logic tr, ex;
    beat_cnt = 0; err_beat = 0;
    do_req(1'b0, 64'h400, '0, lat, rd, tr, ex);
    err_beat = -1;
    checks++;
    if (lat !== 3 || tr !== 1'b1 || rd !== '0) begin
      errors++; $display("FAIL bus_err: lat=%0d trap=%b rdata=%h want 3/1/0", lat, tr, rd);
    end
    checks++; if (beat_cnt !== 1) begin errors++; $display("FAIL bus_err_beats: got %0d want 1", beat_cnt); end
  endtask

  task automatic test_timeout();
    int lat = -1; int hi = 0; logic tr = 1'b0; logic [127:0] rd = '0; int late_rdy = 0;
    gnt_en = 1'b0; beat_cnt = 0;
    core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 64'h300;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus_req_o) hi++;
      if (core_ready_o) begin lat = i; tr = core_trap_o; rd = core_rdata_o; break; end
    end
    core_req_i = 1'b0;
    checks++; if (hi !== 8) begin errors++; $display("FAIL to_req_cycles: got %0d want 8", hi); end
    checks++;
    if (lat !== 9 || tr !== 1'b1 || rd !== '0) begin
      errors++; $display("FAIL to_done: lat=%0d trap=%b rdata=%h want 9/1/0", lat, tr, rd);
    end
    tick();
    late_rv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (core_ready_o || bus_req_o) late_rdy++;
    end
    checks++; if (late_rdy !== 0) begin errors++; $display("FAIL to_late_rvalid: reacted %0d cycles want 0", late_rdy); end
    gnt_en = 1'b1;
  endtask

  task automatic test_reset_midflight();
    int lat; logic [127:0] rd; logic tr, ex;
    beat_cnt = 0;
    core_req_i = 1'b1; core_we_i = 1'b1; core_addr_i = 64'h500; core_wdata_i = {WA, WB};
    for (int i = 0; i < 4; i++) tick();   // now in RSP1
    core_req_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (bus_req_o !== 1'b0 || bus_we_o !== 1'b0 || bus_addr_o !== '0 || bus_wdata_o !== '0 ||
        core_ready_o !== 1'b0 || core_trap_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: req=%b we=%b addr=%h wdata=%h ready=%b trap=%b want all 0",
               bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, core_ready_o, core_trap_o);
    end
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    beat_cnt = 0;
    do_req(1'b0, 64'h600, '0, lat, rd, tr, ex);
    checks++;
    if (lat !== 5 || tr !== 1'b0 || rd !== {D2, D1} || beat_cnt !== 2) begin
      errors++;
      $display("FAIL reset_recover: lat=%0d trap=%b rdata=%h beats=%0d want 5/0/%h/2",
               lat, tr, rd, beat_cnt, {D2, D1});
    end
  endtask

  task automatic test_clk_en();
    int pulses = 0; logic [127:0] rd = '0; logic tr = 1'b1;
    beat_cnt = 0; gnt_en = 1'b0;
    core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 64'h700;
    tick();                               // REQ0
    clk_en_i = 1'b0;
    for (int i = 0; i < 20; i++) tick();  // frozen well past the timeout budget
    checks++;
    if (bus_req_o !== 1'b1 || beat_cnt !== 0 || core_ready_o !== 1'b0) begin
      errors++; $display("FAIL clken_frozen: req=%b beats=%0d ready=%b want 1/0/0", bus_req_o, beat_cnt, core_ready_o);
    end
    gnt_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      clk_en_i = (i % 2 == 0);
      #2;
      if (core_ready_o) begin
        pulses++; rd = core_rdata_o; tr = core_trap_o; core_req_i = 1'b0;
      end
    end
    clk_en_i = 1'b1;
    checks++; if (pulses !== 1) begin errors++; $display("FAIL clken_pulses: got %0d want 1", pulses); end
    checks++;
    if (beat_cnt !== 2 || tr !== 1'b0 || rd !== {D2, D1}) begin
      errors++; $display("FAIL clken_result: beats=%0d trap=%b rdata=%h want 2/0/%h", beat_cnt, tr, rd, {D2, D1});
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_misaligned();
    test_bus_err();
    test_timeout();
    test_reset_midflight();
    test_clk_en();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
